// File: rtl/add_err_pkg.sv
// Shared widths for the approximate-adder error monitor.
// The top-level parameters take their defaults from here.
package add_err_pkg;

  localparam int unsigned W_DEF     = 12;
  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned ACC_W_DEF = 48;

  localparam int unsigned SUM_W = W_DEF + 1;
  localparam int unsigned ERR_W = W_DEF + 2;
  localparam int unsigned SQ_W  = 2 * W_DEF + 2;

endpackage

// File: rtl/sat_acc.sv
// Saturating accumulator with a sticky saturation flag.
// On overflow it clamps at all-ones and raises sat until clr or reset.
module sat_acc #(
  parameter int unsigned Width = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] inc,
  output logic [Width-1:0] q,
  output logic             sat
);

  logic [Width-1:0] q_q, q_d;
  logic             sat_q, sat_d;
  logic [Width:0]   sum;

  assign sum = {1'b0, q_q} + {1'b0, inc};

  always_comb begin
    q_d   = q_q;
    sat_d = sat_q;
    if (clr) begin
      q_d   = '0;
      sat_d = 1'b0;
    end else if (en) begin
      if (sum[Width]) begin
        q_d   = '1;
        sat_d = 1'b1;
      end else begin
        q_d = sum[Width-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      sat_q <= sat_d;
    end
  end

  assign q   = q_q;
  assign sat = sat_q;

endmodule

// File: rtl/add12u_err_monitor.sv
// Error statistics for a W-bit unsigned approximate adder: per-sample signed error
// plus running count, error count, worst-case, sum of |err| and sum of err^2.
module add12u_err_monitor
  import add_err_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_o,
  input  logic             clear,
  output logic             err_valid,
  output logic [W+1:0]     err_value,
  output logic [CNT_W-1:0] stat_count,
  output logic [CNT_W-1:0] stat_err_count,
  output logic [W:0]       stat_wce,
  output logic [ACC_W-1:0] stat_sae,
  output logic [ACC_W-1:0] stat_sse,
  output logic             stat_sat
);

  localparam int unsigned SumW = W + 1;
  localparam int unsigned ErrW = W + 2;
  localparam int unsigned SqW  = 2 * W + 2;

  logic            s1_valid_q;
  logic [SumW-1:0] s1_exact_q, s1_o_q;
  logic            accept, upd;
  logic [ErrW-1:0] err, err_mag;
  logic [SqW-1:0]  err_sq;
  logic            err_nz;
  logic [SumW-1:0] wce_q;
  logic [3:0]      sat_vec;

  assign in_ready = !clear;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_exact_q <= '0;
      s1_o_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_exact_q <= SumW'(in_a) + SumW'(in_b);
        s1_o_q     <= in_o;
      end
    end
  end

  // Zero-extend both to ErrW so the difference is a correct two's complement value.
  assign err     = {1'b0, s1_o_q} - {1'b0, s1_exact_q};
  assign err_mag = err[ErrW-1] ? (~err + ErrW'(1)) : err;
  assign err_sq  = SqW'(err_mag) * SqW'(err_mag);
  assign err_nz  = |err;

  assign err_valid = s1_valid_q;
  assign err_value = err;

  // A sample in stage 2 during a clear cycle is dropped from the statistics.
  assign upd = s1_valid_q && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wce_q <= '0;
    end else if (clear) begin
      wce_q <= '0;
    end else if (upd && (err_mag > {1'b0, wce_q})) begin
      wce_q <= err_mag[SumW-1:0];
    end
  end

  assign stat_wce = wce_q;

  sat_acc #(.Width(CNT_W)) u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (upd),
    .inc   (CNT_W'(1)),
    .q     (stat_count),
    .sat   (sat_vec[0])
  );

  sat_acc #(.Width(CNT_W)) u_err_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (upd),
    .inc   ({{(CNT_W-1){1'b0}}, err_nz}),
    .q     (stat_err_count),
    .sat   (sat_vec[1])
  );

  sat_acc #(.Width(ACC_W)) u_sae (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (upd),
    .inc   ({{(ACC_W-ErrW){1'b0}}, err_mag}),
    .q     (stat_sae),
    .sat   (sat_vec[2])
  );

  sat_acc #(.Width(ACC_W)) u_sse (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (upd),
    .inc   ({{(ACC_W-SqW){1'b0}}, err_sq}),
    .q     (stat_sse),
    .sat   (sat_vec[3])
  );

  assign stat_sat = |sat_vec;

endmodule
